// File: rtl/data_mem_unit.sv
// Multi-cycle load/store data memory for the MEM stage; stalls the pipeline LATENCY cycles per access.
// Optional DMEM_STATS_EN adds load_count/store_count access counters.
module data_mem_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic        stall,
  output logic [31:0] read_data,
  output logic        misaligned
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] load_count,
  output logic [31:0] store_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CntInit = CW'(LATENCY - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          write_q;
  logic          unsigned_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          req, go, done_edge;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [1:0]    acc_size;
  logic          acc_write, acc_unsigned;
  logic [AW-1:0] widx;
  logic [31:0]   rword, shifted, load_val, wdata_rep;
  logic [3:0]    be;

  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  assign req        = mem_read | mem_write;
  assign misaligned = req & (((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00)));
  assign go         = (state_q == StIdle) & req & ~misaligned;
  assign stall      = go | (state_q == StBusy);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (go) begin
          if (LATENCY == 1) begin
            state_d = StDone;
          end else begin
            state_d = StBusy;
            count_d = CntInit;
          end
        end
      end
      StBusy: begin
        if (count_q == CW'(1)) state_d = StDone;
        else                   count_d = count_q - CW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign done_edge = (state_d == StDone) && (state_q != StDone);

  // With LATENCY=1 the access completes straight from IDLE, so use the live inputs there.
  always_comb begin
    if (state_q == StIdle) begin
      acc_addr     = addr[AW+1:0];
      acc_wdata    = write_data;
      acc_size     = size;
      acc_write    = mem_write;
      acc_unsigned = load_unsigned;
    end else begin
      acc_addr     = addr_q;
      acc_wdata    = wdata_q;
      acc_size     = size_q;
      acc_write    = write_q;
      acc_unsigned = unsigned_q;
    end
  end

  assign widx    = acc_addr[AW+1:2];
  assign rword   = mem[widx];
  assign shifted = rword >> {acc_addr[1:0], 3'b000};

  always_comb begin
    case (acc_size)
      2'b00: begin
        load_val  = acc_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        be        = 4'b0001 << acc_addr[1:0];
        wdata_rep = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        load_val  = acc_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        be        = acc_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{acc_wdata[15:0]}};
      end
      default: begin
        load_val  = rword;
        be        = 4'b1111;
        wdata_rep = acc_wdata;
      end
    endcase
  end

  // rst_n gate keeps a LATENCY=1 request held during reset from writing.
  always_ff @(posedge clk) begin
    if (rst_n && done_edge && acc_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      read_data  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (go) begin
        addr_q     <= addr[AW+1:0];
        wdata_q    <= write_data;
        size_q     <= size;
        write_q    <= mem_write;
        unsigned_q <= load_unsigned;
      end
      if (done_edge && !acc_write) read_data <= load_val;
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count  <= '0;
      store_count <= '0;
    end else if (done_edge) begin
      if (acc_write) store_count <= store_count + 32'd1;
      else           load_count  <= load_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit (default DEPTH_WORDS=1024, LATENCY=2).
module tb_data_mem_unit;

  localparam int unsigned Lat = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [1:0]  size = 2'b10;
  logic        load_unsigned = 1'b0;
  logic        stall;
  logic [31:0] read_data;
  logic        misaligned;
`ifdef DMEM_STATS_EN
  logic [31:0] load_count, store_count;
`endif

  int checks = 0;
  int passes = 0;
  int exp_loads = 0;
  int exp_stores = 0;

  data_mem_unit #(
    .DEPTH_WORDS(1024),
    .LATENCY    (Lat)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr         (addr),
    .write_data   (write_data),
    .size         (size),
    .load_unsigned(load_unsigned),
    .stall        (stall),
    .read_data    (read_data),
    .misaligned   (misaligned)
`ifdef DMEM_STATS_EN
    ,
    .load_count   (load_count),
    .store_count  (store_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Issues one access, counts stall cycles (bounded) and returns in IDLE after DONE.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns, input string tag);
    int n;
    @(negedge clk);
    mem_read = ~wr; mem_write = wr; addr = a; write_data = wd; size = sz; load_unsigned = uns;
    n = 0;
    #1;
    while (stall && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, " stall cycles"}, 32'(n), Lat);
    mem_read = 1'b0; mem_write = 1'b0;
    if (wr) exp_stores++;
    else    exp_loads++;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #12;
    check("reset read_data", read_data, 32'h0);
    check("reset stall", {31'b0, stall}, 32'h0);
    check("reset misaligned", {31'b0, misaligned}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store/load
    access(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, "st w 10");
    access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, "ld w 10");
    check("ld w 10 data", read_data, 32'hDEADBEEF);

    // Byte and half lanes in word 0x20
    access(1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, "st w 20");
    access(1'b1, 32'h21, 32'hAAAAAA80, 2'b00, 1'b0, "st b 21");
    access(1'b0, 32'h21, 32'h0, 2'b00, 1'b0, "ld bs 21");
    check("ld bs 21 data", read_data, 32'hFFFFFF80);
    access(1'b0, 32'h21, 32'h0, 2'b00, 1'b1, "ld bu 21");
    check("ld bu 21 data", read_data, 32'h00000080);
    access(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, "ld w 20");
    check("ld w 20 after byte", read_data, 32'h11228044);
    access(1'b0, 32'h22, 32'h0, 2'b01, 1'b0, "ld hs 22");
    check("ld hs 22 data", read_data, 32'h00001122);
    access(1'b1, 32'h22, 32'h7777BEEF, 2'b01, 1'b0, "st h 22");
    access(1'b0, 32'h22, 32'h0, 2'b01, 1'b0, "ld hs 22b");
    check("ld hs 22b data", read_data, 32'hFFFFBEEF);
    access(1'b0, 32'h22, 32'h0, 2'b01, 1'b1, "ld hu 22");
    check("ld hu 22 data", read_data, 32'h0000BEEF);
    access(1'b0, 32'h23, 32'h0, 2'b00, 1'b0, "ld bs 23");
    check("ld bs 23 data", read_data, 32'hFFFFFFBE);
    access(1'b0, 32'h20, 32'h0, 2'b11, 1'b0, "ld w11 20");
    check("ld w(size 11) 20 after half", read_data, 32'hBEEF8044);
    access(1'b0, 32'h10, 32'h0, 2'b10, 1'b1, "ld wu 10");
    check("ld w 10 ignores unsigned", read_data, 32'hDEADBEEF);

    // Misaligned requests
    @(negedge clk);
    mem_read = 1'b1; size = 2'b01; addr = 32'h13;
    #1;
    check("mis half 13 flag", {31'b0, misaligned}, 32'h1);
    check("mis half 13 stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    check("mis half 13 stall later", {31'b0, stall}, 32'h0);
    check("mis half 13 read_data held", read_data, 32'hDEADBEEF);
    addr = 32'h12;
    #1;
    check("half 12 aligned", {31'b0, misaligned}, 32'h0);
    mem_read = 1'b0; addr = 32'h13;
    #1;
    check("no req no flag", {31'b0, misaligned}, 32'h0);
    mem_write = 1'b1; size = 2'b10; addr = 32'h22; write_data = 32'h0;
    #1;
    check("mis word store flag", {31'b0, misaligned}, 32'h1);
    size = 2'b11; addr = 32'h21;
    #1;
    check("mis size11 flag", {31'b0, misaligned}, 32'h1);
    @(negedge clk);
    check("mis store stall", {31'b0, stall}, 32'h0);
    mem_write = 1'b0;
    access(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, "ld w 20 post mis");
    check("mis store left mem", read_data, 32'hBEEF8044);

    // Reset mid-access aborts the store
    access(1'b1, 32'h40, 32'hCAFEF00D, 2'b10, 1'b0, "st w 40");
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h40; write_data = 32'h12345678; size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    check("abort busy stall", {31'b0, stall}, 32'h1);
    #1;
    rst_n = 1'b0; mem_write = 1'b0;
    #1;
    check("abort read_data", read_data, 32'h0);
    check("abort stall", {31'b0, stall}, 32'h0);
    exp_loads = 0; exp_stores = 0;
`ifdef DMEM_STATS_EN
    check("abort store_count", store_count, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, "ld w 40");
    check("abort no write", read_data, 32'hCAFEF00D);

    // Address wrap past DEPTH_WORDS
    access(1'b1, 32'h1000, 32'h5A5AA5A5, 2'b10, 1'b0, "st w 1000");
    access(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, "ld w 0");
    check("wrap data", read_data, 32'h5A5AA5A5);
`ifdef DMEM_STATS_EN
    check("load_count", load_count, 32'(exp_loads));
    check("store_count", store_count, 32'(exp_stores));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
